alien_shots_block: RTL

// - Downward counterpart of the player fire path: launches, moves, draws and retires alien bombs.
// - Shooter position comes from the alien matrix. Bombs fall once per frame.
// - Bombs are killed by the collision block or by reaching the bottom edge.
// - Outputs a drawing request and RGB into the display mux, alongside the player-shot layer.

---
 rtl/space_inv_pkg.sv | 26 ++
 rtl/alien_shot_slot.sv | 122 ++++++++++++
 rtl/alien_shots_block.sv | 122 ++++++++++++
 3 files changed

// File: rtl/space_inv_pkg.sv
// Shared constants and types for the space-invaders shot layers.
// Contents:
//   SHOT_W, SHOT_H     bomb sprite box in pixels
//   SHOT_COLOUR        bomb RGB332 colour
//   SHOT_AIM_OFS       aim point offset from the player's left edge
//   SCREEN_W           visible screen width
//   shot_state_t       per-slot state (free / falling)
//   lfsr_next()        one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
package space_inv_pkg;

  localparam int unsigned SHOT_W       = 2;
  localparam int unsigned SHOT_H       = 16;
  localparam logic [7:0]  SHOT_COLOUR  = 8'hFC;
  localparam int unsigned SHOT_AIM_OFS = 15;
  localparam int unsigned SCREEN_W     = 640;

  typedef enum logic {
    SHOT_FREE,
    SHOT_FALLING
  } shot_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/alien_shot_slot.sv
// One alien bomb slot: state, position, per-frame fall, optional aim and the
// pixel box hit test.
// Optional feature macro: ALIEN_SHOT_AIM_EN (bomb X steps toward the player).
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   clear              free the slot (game not running)
//   launch             load launchX/launchY and start falling (only when free)
//   move               frame tick: fall by SHOT_SPEED, retire at BOTTOM_Y
//   kill               collision kill; wins over move
//   launchX, launchY   launch position
//   aimX               player left X (aim feature only)
//   pixelX, pixelY     current VGA pixel
//   alive              slot is falling
//   hit                slot is alive and the pixel is inside its box
module alien_shot_slot
  import space_inv_pkg::*;
#(
  parameter int unsigned SHOT_SPEED = 4,
  parameter int unsigned BOTTOM_Y   = 464
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        launch,
  input  logic        move,
  input  logic        kill,
  input  logic [10:0] launchX,
  input  logic [10:0] launchY,
  input  logic [10:0] aimX,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        alive,
  output logic        hit
);

  shot_state_t state, state_n;
  logic [10:0] x, x_n, y, y_n;
  logic [11:0] y_step;
  logic [10:0] x_aim;

`ifdef ALIEN_SHOT_AIM_EN
  localparam logic [11:0] X_MAX = 12'(SCREEN_W - 1 - SHOT_W);
  logic [11:0] target;
  logic [11:0] x_ext;

  always_comb begin
    target = {1'b0, aimX} + 12'(SHOT_AIM_OFS);
    x_ext  = {1'b0, x};
    if (target > x_ext) begin
      x_ext = x_ext + 12'd1;
    end else if (target < x_ext) begin
      x_ext = x_ext - 12'd1;
    end
    if (x_ext > X_MAX) begin
      x_ext = X_MAX;
    end
    x_aim = x_ext[10:0];
  end
`else
  logic unused_aim;
  assign unused_aim = ^aimX;
  assign x_aim      = x;
`endif

  // 12-bit sum so a bomb near the bottom of the 11-bit range cannot wrap
  assign y_step = {1'b0, y} + 12'(SHOT_SPEED);

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    if (clear) begin
      state_n = SHOT_FREE;
      x_n     = '0;
      y_n     = '0;
    end else begin
      case (state)
        SHOT_FREE: begin
          if (launch) begin
            state_n = SHOT_FALLING;
            x_n     = launchX;
            y_n     = launchY;
          end
        end
        SHOT_FALLING: begin
          if (kill) begin
            state_n = SHOT_FREE;
          end else if (move) begin
            if (y_step >= 12'(BOTTOM_Y)) begin
              state_n = SHOT_FREE;
            end else begin
              y_n = y_step[10:0];
              x_n = x_aim;
            end
          end
        end
        default: state_n = SHOT_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= SHOT_FREE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  assign alive = (state == SHOT_FALLING);

  assign hit = alive
            && ({1'b0, pixelX} >= {1'b0, x})
            && ({1'b0, pixelX} <  ({1'b0, x} + 12'(SHOT_W)))
            && ({1'b0, pixelY} >= {1'b0, y})
            && ({1'b0, pixelY} <  ({1'b0, y} + 12'(SHOT_H)));

endmodule

// File: rtl/alien_shots_block.sv
// Alien bomb layer: launches bombs from the selected alien, moves them down
// once per frame, retires them at the bottom or on collision, and draws them.
// Optional feature macro: ALIEN_SHOT_AIM_EN (bombs drift toward the player).
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   pixelX, pixelY            current VGA pixel
//   startOfFrame              one-cycle frame pulse
//   shooterX/Y, shooterValid  launch position from the alien matrix
//   playerXPosition           player left X (aim feature only)
//   shotCollision             drawn bomb pixel overlaps player/shield
//   standBy, gameEnded        pause / game over (freeze and clear)
//   alienShotRGB, alienShotDR registered colour and draw request
//   shotsAlive                per-slot alive flags
//   newAlienFire              one-cycle pulse per launch
module alien_shots_block
  import space_inv_pkg::*;
#(
  parameter int unsigned NUM_SHOTS   = 3,
  parameter int unsigned SHOT_SPEED  = 4,
  parameter int unsigned BOTTOM_Y    = 464,
  parameter int unsigned FIRE_PERIOD = 40,
  parameter logic [7:0]  JITTER_MASK = 8'h1F
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic                 startOfFrame,
  input  logic [10:0]          shooterX,
  input  logic [10:0]          shooterY,
  input  logic                 shooterValid,
  input  logic [10:0]          playerXPosition,
  input  logic                 shotCollision,
  input  logic                 standBy,
  input  logic                 gameEnded,
  output logic [7:0]           alienShotRGB,
  output logic                 alienShotDR,
  output logic [NUM_SHOTS-1:0] shotsAlive,
  output logic                 newAlienFire
);

  localparam int unsigned CD_W = 12;

  logic                 play_game;
  logic                 fire_now;
  logic                 any_free;
  logic [NUM_SHOTS-1:0] alive, hit_vec, hit_q, kill_vec, launch_vec;
  logic [CD_W-1:0]      cooldown;
  logic [7:0]           lfsr;

  assign play_game = ~(standBy | gameEnded);

  // Lowest-index free slot; alive is the pre-move state so a slot retiring
  // this frame is not reused until the next one.
  always_comb begin
    launch_vec = '0;
    any_free   = 1'b0;
    for (int unsigned i = 0; i < NUM_SHOTS; i++) begin
      if (!alive[i] && !any_free) begin
        launch_vec[i] = 1'b1;
        any_free      = 1'b1;
      end
    end
  end

  assign fire_now = startOfFrame & play_game & (cooldown == '0) & shooterValid & any_free;

  // Collision is aligned with the registered draw request, so kill exactly
  // the slots that produced it.
  assign kill_vec = hit_q & {NUM_SHOTS{shotCollision}};

  for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
    alien_shot_slot #(
      .SHOT_SPEED (SHOT_SPEED),
      .BOTTOM_Y   (BOTTOM_Y)
    ) u_slot (
      .clk     (clk),
      .resetN  (resetN),
      .clear   (~play_game),
      .launch  (fire_now & launch_vec[g]),
      .move    (startOfFrame & play_game),
      .kill    (kill_vec[g]),
      .launchX (shooterX),
      .launchY (shooterY),
      .aimX    (playerXPosition),
      .pixelX  (pixelX),
      .pixelY  (pixelY),
      .alive   (alive[g]),
      .hit     (hit_vec[g])
    );
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cooldown     <= CD_W'(FIRE_PERIOD);
      lfsr         <= 8'hA5;
      hit_q        <= '0;
      alienShotRGB <= '0;
      newAlienFire <= 1'b0;
    end else begin
      hit_q        <= hit_vec;
      alienShotRGB <= (|hit_vec) ? SHOT_COLOUR : 8'h00;
      newAlienFire <= fire_now;
      if (startOfFrame) begin
        lfsr <= lfsr_next(lfsr);
      end
      if (!play_game) begin
        cooldown <= CD_W'(FIRE_PERIOD);
      end else if (startOfFrame) begin
        if (cooldown != '0) begin
          cooldown <= cooldown - 1'b1;
        end else if (fire_now) begin
          cooldown <= CD_W'(FIRE_PERIOD) + CD_W'(lfsr & JITTER_MASK);
        end
      end
    end
  end

  assign alienShotDR = |hit_q;
  assign shotsAlive  = alive;

endmodule
